// File: rtl/kuba_wb_arbiter_pkg.sv
// Shared types and constants for the kuba Wishbone B3 round-robin arbiter.
package kuba_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Supports up to eight masters, the widest configuration the arbiter allows.
  function automatic logic [2:0] onehotToIdx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kuba_wb_arbiter_if.sv
// Wishbone bundle between the masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface kuba_wb_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
  logic [DW-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;
  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o
  );
endinterface

// File: rtl/kuba_wb_arbiter_rr_picker.sv
// Combinational round-robin pick: one-hot grant for the first requester at or after ptr_i.
module kuba_rr_picker #(
  parameter int N = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  // Scan from the farthest position back to ptr_i so the nearest requester is written last.
  always_comb begin
    int idx;
    idx   = 0;
    gnt_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kuba_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave between NUM_MASTERS masters.
// Grant is held for a whole cyc assertion; a watchdog aborts stalled strobes with err.
module kuba_wb_arbiter
  import kuba_wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  kuba_wb_arbiter_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DW / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic [PW-1:0]          gIdx_q, gIdx_d, ptr_q, ptr_d;
  logic [WW-1:0]          wdog_q, wdog_d;
  logic                   abortFirst_q, abortFirst_d;
  logic                   gCyc, gStb, slvResp, wdogExpired, inBusy;

  kuba_rr_picker #(.N(NUM_MASTERS)) uPicker (
    .req_i (bus.wbm_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  assign gCyc        = bus.wbm_cyc_i[gIdx_q];
  assign gStb        = bus.wbm_stb_i[gIdx_q];
  assign slvResp     = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign wdogExpired = (TIMEOUT != 0) && (wdog_q == WW'(TIMEOUT));
  assign inBusy      = (state_q == ST_BUSY);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gIdx_d       = gIdx_q;
    ptr_d        = ptr_q;
    wdog_d       = '0;
    abortFirst_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.wbm_cyc_i) begin
          state_d = ST_BUSY;
          grant_d = pick;
          gIdx_d  = PW'(onehotToIdx(8'(pick)));
        end
      end
      ST_BUSY: begin
        if (!gCyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (gIdx_q == PW'(NUM_MASTERS - 1)) ? '0 : gIdx_q + 1'b1;
        end else if (wdogExpired) begin
          state_d      = ST_ABORT;
          abortFirst_d = 1'b1;
        end else if (gStb && !slvResp) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_ABORT: begin
        // The aborted master keeps its turn until it lets go of cyc.
        if (!gCyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gIdx_q       <= '0;
      ptr_q        <= '0;
      wdog_q       <= '0;
      abortFirst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gIdx_q       <= gIdx_d;
      ptr_q        <= ptr_d;
      wdog_q       <= wdog_d;
      abortFirst_q <= abortFirst_d;
    end
  end

  // Slave responses only reach the granted master while BUSY; late ones are dropped.
  assign bus.wbs_cyc_o = inBusy & gCyc;
  assign bus.wbs_stb_o = inBusy & gStb;
  assign bus.wbm_ack_o = {NUM_MASTERS{inBusy & bus.wbs_ack_i}} & grant_q;
  assign bus.wbm_rty_o = {NUM_MASTERS{inBusy & bus.wbs_rty_i}} & grant_q;
  assign bus.wbm_err_o = {NUM_MASTERS{(inBusy & bus.wbs_err_i) | abortFirst_q}} & grant_q;
  assign bus.wbm_dat_o = bus.wbs_dat_i;

  assign bus.wbs_adr_o = bus.wbm_adr_i[gIdx_q*AW +: AW];
  assign bus.wbs_dat_o = bus.wbm_dat_i[gIdx_q*DW +: DW];
  assign bus.wbs_sel_o = bus.wbm_sel_i[gIdx_q*SW +: SW];
  assign bus.wbs_we_o  = bus.wbm_we_i[gIdx_q];
  assign bus.wbs_cti_o = bus.wbm_cti_i[gIdx_q*3 +: 3];
  assign bus.wbs_bte_o = bus.wbm_bte_i[gIdx_q*2 +: 2];

  assign grant_o   = grant_q;
  assign timeout_o = abortFirst_q;

endmodule

// File: tb/tb_kuba_wb_arbiter.sv
// Directed bench for kuba_wb_arbiter: two scripted masters, a scripted slave, and a
// transaction-level arbitration model checked against the DUT on every cycle.
module tb_kuba_wb_arbiter;
  import kuba_wb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] grantO;
  logic timeoutO;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  kuba_wb_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  kuba_wb_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .grant_o   (grantO),
    .timeout_o (timeoutO)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- master scripts ----------------
  int beatsLeft[N], beatsTotal[N], beatIdx[N], gapAfter[N], gapCycles[N];
  bit [N-1:0] ackSeen = '0, errSeen = '0, rtySeen = '0;

  task automatic applyStimulus(input int k, input int beats, input int gap);
    beatsLeft[k]  = beats;
    beatsTotal[k] = beats;
    beatIdx[k]    = 0;
    gapAfter[k]   = gap;
    gapCycles[k]  = 0;
  endtask

  initial begin
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = '0;
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
    for (int k = 0; k < N; k++) applyStimulus(k, 0, 0);
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (beatsLeft[k] > 0 && bus.wbm_stb_i[k] && (ackSeen[k] || errSeen[k] || rtySeen[k])) begin
          if (ackSeen[k]) begin
            beatsLeft[k]--;
            beatIdx[k]++;
            if (beatIdx[k] == gapAfter[k] && beatsLeft[k] > 0) gapCycles[k] = 1;
          end else begin
            beatsLeft[k] = 0;
          end
        end else if (gapCycles[k] > 0 && !bus.wbm_stb_i[k]) begin
          gapCycles[k] = 0;
        end
        bus.wbm_cyc_i[k]          = (beatsLeft[k] > 0);
        bus.wbm_stb_i[k]          = (beatsLeft[k] > 0) && (gapCycles[k] == 0);
        bus.wbm_adr_i[k*AW +: AW] = AW'(32'h1000_0000 * (k + 1) + 4 * beatIdx[k]);
        bus.wbm_dat_i[k*DW +: DW] = {16'hDA7A, 8'(k), 8'(beatIdx[k])};
        bus.wbm_sel_i[k*4 +: 4]   = 4'hF;
        bus.wbm_we_i[k]           = (k == 1);
        bus.wbm_cti_i[k*3 +: 3]   = (beatsTotal[k] <= 1) ? CTI_CLASSIC :
                                    (beatsLeft[k] == 1) ? CTI_EOB : CTI_INC;
        bus.wbm_bte_i[k*2 +: 2]   = BTE_LINEAR;
      end
    end
  end

  // ---------------- slave script: mode 0 ack, 1 err, 2 rty, 3 never ----------------
  int slaveMode = 0;
  int slaveLatency = 1;
  int waitCnt = 0;

  initial begin
    bus.wbs_ack_i = 1'b0; bus.wbs_err_i = 1'b0; bus.wbs_rty_i = 1'b0; bus.wbs_dat_i = '0;
    forever begin
      @(posedge clk); #2;
      bus.wbs_ack_i = 1'b0; bus.wbs_err_i = 1'b0; bus.wbs_rty_i = 1'b0;
      bus.wbs_dat_i = bus.wbs_adr_o ^ 32'hA5A5_0000;
      if (bus.wbs_cyc_o && bus.wbs_stb_o && slaveMode != 3) begin
        if (waitCnt >= slaveLatency) begin
          waitCnt = 0;
          case (slaveMode)
            0:       bus.wbs_ack_i = 1'b1;
            1:       bus.wbs_err_i = 1'b1;
            default: bus.wbs_rty_i = 1'b1;
          endcase
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // ---------------- arbitration model: who owns the slave, and for how long ----------------
  int mOwner = -1, mPtr = 0, mStall = 0, mAbortAge = 0;
  bit mAborting = 0, mValid = 0;

  initial begin
    int c;
    forever begin
      @(posedge clk);
      if (rst) begin
        mOwner = -1; mPtr = 0; mStall = 0; mAborting = 0; mValid = 1;
      end else if (mValid) begin
        if (mOwner < 0) begin
          for (int j = 0; j < N; j++) begin
            c = (mPtr + j) % N;
            if (mOwner < 0 && bus.wbm_cyc_i[c]) mOwner = c;
          end
          mStall = 0;
        end else if (!bus.wbm_cyc_i[mOwner]) begin
          if (!mAborting) mPtr = (mOwner + 1) % N;
          mOwner = -1;
          mAborting = 0;
        end else if (mAborting) begin
          mAbortAge++;
        end else if (mStall == TO) begin
          mAborting = 1;
          mAbortAge = 0;
        end else if (bus.wbm_stb_i[mOwner] && !(bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i)) begin
          mStall++;
        end else begin
          mStall = 0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] expGrant, expAck, expErr, expRty;
    logic expCyc, expStb, expTo;
    bit active;
    forever begin
      @(negedge clk);
      if (mValid) begin
        expGrant = (mOwner < 0) ? '0 : (N'(1) << mOwner);
        active   = (mOwner >= 0) && !mAborting;
        expCyc = 1'b0; expStb = 1'b0;
        if (active) begin
          expCyc = bus.wbm_cyc_i[mOwner];
          expStb = bus.wbm_stb_i[mOwner];
        end
        expTo  = mAborting && (mAbortAge == 0);
        expAck = (active && bus.wbs_ack_i) ? expGrant : '0;
        expRty = (active && bus.wbs_rty_i) ? expGrant : '0;
        expErr = ((active && bus.wbs_err_i) || expTo) ? expGrant : '0;
        checkOutput("grant", grantO, expGrant);
        checkOutput("wbs_cyc", bus.wbs_cyc_o, expCyc);
        checkOutput("wbs_stb", bus.wbs_stb_o, expStb);
        checkOutput("ack", bus.wbm_ack_o, expAck);
        checkOutput("err", bus.wbm_err_o, expErr);
        checkOutput("rty", bus.wbm_rty_o, expRty);
        checkOutput("timeout", timeoutO, expTo);
        checkOutput("dat_o", bus.wbm_dat_o, bus.wbs_dat_i);
        if (active) begin
          checkOutput("adr_mux", bus.wbs_adr_o, bus.wbm_adr_i[mOwner*AW +: AW]);
          checkOutput("dat_mux", bus.wbs_dat_o, bus.wbm_dat_i[mOwner*DW +: DW]);
          checkOutput("sel_mux", bus.wbs_sel_o, bus.wbm_sel_i[mOwner*4 +: 4]);
          checkOutput("we_mux", bus.wbs_we_o, bus.wbm_we_i[mOwner]);
          checkOutput("cti_mux", bus.wbs_cti_o, bus.wbm_cti_i[mOwner*3 +: 3]);
          checkOutput("bte_mux", bus.wbs_bte_o, bus.wbm_bte_i[mOwner*2 +: 2]);
        end
      end
      ackSeen = bus.wbm_ack_o;
      errSeen = bus.wbm_err_o;
      rtySeen = bus.wbm_rty_o;
    end
  end

  // ---------------- directed sequence helpers ----------------
  task automatic doReset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic waitGrant(input logic [N-1:0] exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (grantO == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, grantO, exp);
  endtask

  task automatic handover(input logic [N-1:0] from, input logic [N-1:0] to, input string name);
    int n;
    n = 0;
    while (grantO == from && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle_gap"}, grantO, '0);
    @(negedge clk);
    checkOutput({name, "_next"}, grantO, to);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((beatsLeft[0] > 0 || beatsLeft[1] > 0 || grantO != '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, grantO, '0);
  endtask

  initial begin
    bit sawGap;
    int n;
    #100000;
    $display("[TB] FAIL global_timeout: got no finish, wanted finish before 100000");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bit sawGap;
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_grant", grantO, 2'b00);
    checkOutput("rst_cyc", bus.wbs_cyc_o, 1'b0);
    checkOutput("rst_ack", bus.wbm_ack_o, 2'b00);
    checkOutput("rst_err", bus.wbm_err_o, 2'b00);
    checkOutput("rst_timeout", timeoutO, 1'b0);
    #1 rst = 1'b0;

    // M0 single read, slave answers on its second strobe cycle
    applyStimulus(0, 1, 0);
    @(negedge clk); checkOutput("t1_cyc_latency", bus.wbs_cyc_o, 1'b0);
    @(negedge clk); checkOutput("t1_cyc", bus.wbs_cyc_o, 1'b1);
    checkOutput("t1_grant", grantO, 2'b01);
    @(negedge clk); checkOutput("t1_ack", bus.wbm_ack_o, 2'b01);
    checkOutput("t1_dat", bus.wbm_dat_o, 32'hB5A5_0000);
    waitIdle("t1_idle");

    // Contention from pointer 0, then contention after M0 was served alone
    doReset();
    applyStimulus(0, 2, 0);
    applyStimulus(1, 1, 0);
    waitGrant(2'b01, "t2_first_m0");
    handover(2'b01, 2'b10, "t2");
    waitIdle("t2_idle_a");
    applyStimulus(0, 1, 0);
    waitGrant(2'b01, "t2_m0_alone");
    waitIdle("t2_idle_b");
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    waitGrant(2'b10, "t2_rr_m1_first");
    handover(2'b10, 2'b01, "t2_rr");
    waitIdle("t2_idle_c");

    // M1 4-beat burst with a strobe gap; M0 must wait for M1 to drop cyc
    applyStimulus(1, 4, 2);
    waitGrant(2'b10, "t3_burst_grant");
    applyStimulus(0, 1, 0);
    sawGap = 0;
    n = 0;
    while (beatsLeft[1] > 0 && n < 100) begin
      @(negedge clk);
      checkOutput("t3_hold", grantO, 2'b10);
      if (bus.wbs_cyc_o && !bus.wbs_stb_o) sawGap = 1;
      n++;
    end
    checkOutput("t3_gap_seen", sawGap, 1'b1);
    handover(2'b10, 2'b01, "t3");
    waitIdle("t3_idle");

    // Watchdog: slave never answers; err on the cycle after the ninth stalled strobe
    doReset();
    slaveMode = 3;
    applyStimulus(0, 1, 0);
    waitGrant(2'b01, "t4_grant");
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      checkOutput("t4_no_early_err", bus.wbm_err_o, 2'b00);
      checkOutput("t4_stb_stalled", bus.wbs_stb_o, 1'b1);
    end
    @(negedge clk);
    checkOutput("t4_abort_err", bus.wbm_err_o, 2'b01);
    checkOutput("t4_timeout_pulse", timeoutO, 1'b1);
    checkOutput("t4_abort_cyc", bus.wbs_cyc_o, 1'b0);
    @(negedge clk);
    checkOutput("t4_err_once", bus.wbm_err_o, 2'b00);
    checkOutput("t4_timeout_once", timeoutO, 1'b0);
    waitIdle("t4_idle");
    slaveMode = 0;

    // Reset in the middle of a burst; arbitration restarts from M0
    doReset();
    slaveLatency = 0;
    applyStimulus(0, 1, 0);
    waitGrant(2'b01, "t5_m0_single");
    waitIdle("t5_idle_a");
    slaveLatency = 1;
    applyStimulus(0, 8, 0);
    waitGrant(2'b01, "t5_burst_grant");
    repeat (3) @(negedge clk);
    applyStimulus(1, 4, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_cyc", bus.wbs_cyc_o, 1'b0);
    checkOutput("t5_reset_grant", grantO, 2'b00);
    #1 rst = 1'b0;
    waitGrant(2'b01, "t5_rearb_m0");
    waitIdle("t5_idle_b");

    // Slave err then rty, each routed only to the granted master
    doReset();
    slaveMode = 1;
    slaveLatency = 0;
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    waitGrant(2'b01, "t6_grant_m0");
    checkOutput("t6_err_m0", bus.wbm_err_o, 2'b01);
    checkOutput("t6_ack_none", bus.wbm_ack_o, 2'b00);
    checkOutput("t6_rty_none", bus.wbm_rty_o, 2'b00);
    slaveMode = 2;
    handover(2'b01, 2'b10, "t6");
    checkOutput("t6_rty_m1", bus.wbm_rty_o, 2'b10);
    checkOutput("t6_err_none", bus.wbm_err_o, 2'b00);
    checkOutput("t6_ack_none2", bus.wbm_ack_o, 2'b00);
    waitIdle("t6_idle");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
